// File: rtl/smbus_regbank_arbiter.sv
// rtl/smbus_regbank_arbiter.sv - SMBus/local shared 8-bit register bank with sticky event register
// Optional write lock on register NUM_REGS-1 bit0: define SMBREG_WRLOCK_EN.
module smbus_regbank_arbiter #(
  parameter int          NUM_REGS = 16,
  parameter logic [7:0]  EVT_ADDR = 8'h00,
  parameter logic [7:0]  RST_VAL  = 8'h00,
  parameter int          TP       = 1
) (
  input  logic                  CLK_IN,
  input  logic                  RESET_N,
  input  logic [7:0]            SMB_CMD_I,
  input  logic [7:0]            SMB_DAT_I,
  input  logic                  SMB_WREN,
  input  logic                  SMB_RDEN,
  output logic [7:0]            SMB_DAT_O,
  input  logic                  LCL_REQ,
  input  logic                  LCL_WE,
  input  logic [7:0]            LCL_ADR,
  input  logic [7:0]            LCL_WDAT,
  output logic                  LCL_ACK,
  output logic [7:0]            LCL_RDAT,
  input  logic [7:0]            EVT_I,
  output logic                  REG_CHG,
  output logic [7:0]            REG_CHG_ADR,
  output logic [NUM_REGS*8-1:0] REGS_O
);

  localparam logic [7:0] NREG_ADR = 8'(NUM_REGS);
  localparam int         EVT_IDX  = int'(EVT_ADDR);

  // Illegal configurations get a visibly named empty scope; TP has no hardware meaning.
  if (NUM_REGS < 2 || NUM_REGS > 254 || EVT_IDX >= NUM_REGS || TP < 0) begin : g_illegal_params
  end

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_WAIT = 2'd1,
    L_ACK  = 2'd2
  } lstate_t;

  logic [7:0] bank_q [NUM_REGS];

  lstate_t    lstate_q;
  logic       lwe_q;
  logic [7:0] ladr_q;
  logic [7:0] lwdat_q;
  logic       lcl_ack_q;
  logic [7:0] lcl_rdat_q;
  logic       reg_chg_q;
  logic [7:0] reg_chg_adr_q;

  logic       lcl_we_eff;
  logic [7:0] lcl_adr_eff;
  logic [7:0] lcl_wdat_eff;
  logic       lcl_go;
  logic       smb_locked;
  logic       smb_hit;
  logic       lcl_hit;
  logic       lcl_w1c;
  logic       wr_en;
  logic [7:0] wr_adr;
  logic [7:0] wr_dat;
  logic [7:0] evt_cur;
  logic [7:0] evt_clr;
  logic [7:0] evt_d;
  logic       reg_chg_d;
  logic [7:0] reg_chg_adr_d;
  logic [7:0] smb_rdat;
  logic [7:0] lcl_rdat_mux;

  // Reset value per register: event register clears to 0, lock bit (if present) clears to 0.
  function automatic logic [7:0] reg_rst_val(input int k);
    if (k == EVT_IDX) return 8'h00;
`ifdef SMBREG_WRLOCK_EN
    if (k == NUM_REGS - 1) return RST_VAL & 8'hFE;
`endif
    return RST_VAL;
  endfunction

  // Local access fields: live inputs in L_IDLE, latched copies once deferred.
  always_comb begin
    lcl_we_eff   = (lstate_q == L_IDLE) ? LCL_WE   : lwe_q;
    lcl_adr_eff  = (lstate_q == L_IDLE) ? LCL_ADR  : ladr_q;
    lcl_wdat_eff = (lstate_q == L_IDLE) ? LCL_WDAT : lwdat_q;
    lcl_go       = !SMB_WREN && (((lstate_q == L_IDLE) && LCL_REQ) || (lstate_q == L_WAIT));
  end

  // Read muxes: SMBus side is purely combinational so auto-increment sees new data at once.
  always_comb begin
    smb_rdat     = 8'hFF;
    lcl_rdat_mux = 8'hFF;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (SMB_CMD_I == 8'(k)) smb_rdat = bank_q[k];
      if (lcl_adr_eff == 8'(k)) lcl_rdat_mux = bank_q[k];
    end
  end

  assign SMB_DAT_O = smb_rdat;

  // Write arbitration: SMBus always wins; local only proceeds in cycles without SMB_WREN.
  always_comb begin
`ifdef SMBREG_WRLOCK_EN
    smb_locked = bank_q[NUM_REGS-1][0] && (SMB_CMD_I != 8'(NUM_REGS - 1));
`else
    smb_locked = 1'b0;
`endif
    smb_hit = SMB_WREN && (SMB_CMD_I < NREG_ADR) && (SMB_CMD_I != EVT_ADDR) && !smb_locked;
    lcl_hit = lcl_go && lcl_we_eff && (lcl_adr_eff < NREG_ADR);
    lcl_w1c = lcl_hit && (lcl_adr_eff == EVT_ADDR);

    wr_en  = smb_hit || (lcl_hit && !lcl_w1c);
    wr_adr = smb_hit ? SMB_CMD_I : lcl_adr_eff;
    wr_dat = smb_hit ? SMB_DAT_I : lcl_wdat_eff;

    reg_chg_d     = smb_hit || lcl_hit;
    reg_chg_adr_d = smb_hit ? SMB_CMD_I : lcl_adr_eff;
  end

  // Sticky events: clear-on-read and local W1C remove old bits, new events always win.
  always_comb begin
    evt_cur = bank_q[EVT_IDX];
    evt_clr = 8'h00;
    if (SMB_RDEN && (SMB_CMD_I == EVT_ADDR)) evt_clr = evt_clr | evt_cur;
    if (lcl_w1c) evt_clr = evt_clr | lcl_wdat_eff;
    evt_d = (evt_cur & ~evt_clr) | EVT_I;
  end

  // Register bank storage: at most one general write per cycle plus the event update.
  always_ff @(posedge CLK_IN) begin
    if (!RESET_N) begin
      for (int k = 0; k < NUM_REGS; k++) bank_q[k] <= reg_rst_val(k);
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (k == EVT_IDX) begin
          bank_q[k] <= evt_d;
        end else if (wr_en && (wr_adr == 8'(k))) begin
          bank_q[k] <= wr_dat;
        end
      end
    end
  end

  // Change strobe: one pulse per committed write, address held between pulses.
  always_ff @(posedge CLK_IN) begin
    if (!RESET_N) begin
      reg_chg_q     <= 1'b0;
      reg_chg_adr_q <= 8'h00;
    end else begin
      reg_chg_q <= reg_chg_d;
      if (reg_chg_d) reg_chg_adr_q <= reg_chg_adr_d;
    end
  end

  // Local REQ/ACK handshake: immediate service, or deferred while SMBus writes keep coming.
  always_ff @(posedge CLK_IN) begin
    if (!RESET_N) begin
      lstate_q   <= L_IDLE;
      lcl_ack_q  <= 1'b0;
      lcl_rdat_q <= 8'h00;
      lwe_q      <= 1'b0;
      ladr_q     <= 8'h00;
      lwdat_q    <= 8'h00;
    end else begin
      case (lstate_q)
        L_IDLE: begin
          lcl_ack_q <= 1'b0;
          if (LCL_REQ) begin
            if (SMB_WREN) begin
              lwe_q    <= LCL_WE;
              ladr_q   <= LCL_ADR;
              lwdat_q  <= LCL_WDAT;
              lstate_q <= L_WAIT;
            end else begin
              lcl_rdat_q <= lcl_rdat_mux;
              lcl_ack_q  <= 1'b1;
              lstate_q   <= L_ACK;
            end
          end
        end
        L_WAIT: begin
          if (!SMB_WREN) begin
            lcl_rdat_q <= lcl_rdat_mux;
            lcl_ack_q  <= 1'b1;
            lstate_q   <= L_ACK;
          end
        end
        L_ACK: begin
          lcl_ack_q <= 1'b0;
          lstate_q  <= L_IDLE;
        end
        default: begin
          lcl_ack_q <= 1'b0;
          lstate_q  <= L_IDLE;
        end
      endcase
    end
  end

  assign LCL_ACK     = lcl_ack_q;
  assign LCL_RDAT    = lcl_rdat_q;
  assign REG_CHG     = reg_chg_q;
  assign REG_CHG_ADR = reg_chg_adr_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_image
    assign REGS_O[g*8 +: 8] = bank_q[g];
  end

endmodule

// File: tb/tb_smbus_regbank_arbiter.sv
// tb/tb_smbus_regbank_arbiter.sv - directed table, corner sequences and random model check
module tb_smbus_regbank_arbiter;

  localparam int NR = 16;
  localparam logic [7:0] EVT = 8'h00;

  logic          CLK_IN = 1'b0;
  logic          RESET_N;
  logic [7:0]    SMB_CMD_I, SMB_DAT_I;
  logic          SMB_WREN, SMB_RDEN;
  logic [7:0]    SMB_DAT_O;
  logic          LCL_REQ, LCL_WE;
  logic [7:0]    LCL_ADR, LCL_WDAT;
  logic          LCL_ACK;
  logic [7:0]    LCL_RDAT;
  logic [7:0]    EVT_I;
  logic          REG_CHG;
  logic [7:0]    REG_CHG_ADR;
  logic [NR*8-1:0] REGS_O;

  int errors = 0;
  int checks = 0;

  smbus_regbank_arbiter #(.NUM_REGS(NR), .EVT_ADDR(EVT), .RST_VAL(8'h00), .TP(1)) dut (
    .CLK_IN(CLK_IN), .RESET_N(RESET_N),
    .SMB_CMD_I(SMB_CMD_I), .SMB_DAT_I(SMB_DAT_I), .SMB_WREN(SMB_WREN), .SMB_RDEN(SMB_RDEN),
    .SMB_DAT_O(SMB_DAT_O),
    .LCL_REQ(LCL_REQ), .LCL_WE(LCL_WE), .LCL_ADR(LCL_ADR), .LCL_WDAT(LCL_WDAT),
    .LCL_ACK(LCL_ACK), .LCL_RDAT(LCL_RDAT),
    .EVT_I(EVT_I), .REG_CHG(REG_CHG), .REG_CHG_ADR(REG_CHG_ADR), .REGS_O(REGS_O)
  );

  always #5 CLK_IN = ~CLK_IN;

  typedef struct {
    logic       wren;  logic [7:0] cmd;  logic [7:0] dat;  logic rden;  logic [7:0] evt;
    logic       lreq;  logic lwe;  logic [7:0] ladr;  logic [7:0] lwdat;
    logic [7:0] e_dato;
    logic       e_chg; logic [7:0] e_chg_adr;
    logic       e_ack; logic rd_chk; logic [7:0] e_rdat;
    int         bidx;  logic [7:0] e_bank;
  } vec_t;

  vec_t vecs[$];

  // reference model state
  logic [7:0] m_bank [NR];
  logic       m_pend, m_pwe, m_ack, m_rd, m_chg;
  logic [7:0] m_padr, m_pwdat, m_rdat, m_chg_adr;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic wren, logic [7:0] cmd, logic [7:0] dat, logic rden, logic [7:0] evt,
                              logic lreq, logic lwe, logic [7:0] ladr, logic [7:0] lwdat,
                              logic [7:0] e_dato, logic e_chg, logic [7:0] e_chg_adr,
                              logic e_ack, logic rd_chk, logic [7:0] e_rdat, int bidx, logic [7:0] e_bank);
    vec_t v;
    v.wren = wren; v.cmd = cmd; v.dat = dat; v.rden = rden; v.evt = evt;
    v.lreq = lreq; v.lwe = lwe; v.ladr = ladr; v.lwdat = lwdat;
    v.e_dato = e_dato; v.e_chg = e_chg; v.e_chg_adr = e_chg_adr;
    v.e_ack = e_ack; v.rd_chk = rd_chk; v.e_rdat = e_rdat; v.bidx = bidx; v.e_bank = e_bank;
    return v;
  endfunction

  task automatic drive(input logic wren, input logic [7:0] cmd, input logic [7:0] dat, input logic rden,
                       input logic [7:0] evt, input logic lreq, input logic lwe, input logic [7:0] ladr,
                       input logic [7:0] lwdat);
    SMB_WREN = wren; SMB_CMD_I = cmd; SMB_DAT_I = dat; SMB_RDEN = rden; EVT_I = evt;
    LCL_REQ = lreq; LCL_WE = lwe; LCL_ADR = ladr; LCL_WDAT = lwdat;
  endtask

  task automatic tick();
    @(posedge CLK_IN);
    @(negedge CLK_IN);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLK_IN);
    @(negedge CLK_IN);
    RESET_N = 1'b1;
    for (int k = 0; k < NR; k++) m_bank[k] = 8'h00;
    m_pend = 0; m_pwe = 0; m_ack = 0; m_rd = 0; m_chg = 0;
    m_padr = 0; m_pwdat = 0; m_rdat = 0; m_chg_adr = 0;
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    return (a < 8'(NR)) ? m_bank[a[3:0]] : 8'hFF;
  endfunction

  // One clock edge of the register bank, expressed as transaction rules.
  task automatic model_edge();
    logic [7:0] old [NR];
    logic [7:0] clr;
    logic       chg;
    logic [7:0] cadr;
    logic       locked;
    for (int k = 0; k < NR; k++) old[k] = m_bank[k];
    chg = 0; cadr = 0; clr = 0;
    locked = 0;
`ifdef SMBREG_WRLOCK_EN
    locked = old[NR-1][0] && (SMB_CMD_I != 8'(NR-1));
`endif
    if (SMB_WREN && SMB_CMD_I < 8'(NR) && SMB_CMD_I != EVT && !locked) begin
      m_bank[SMB_CMD_I[3:0]] = SMB_DAT_I;
      chg = 1; cadr = SMB_CMD_I;
    end
    if (SMB_RDEN && SMB_CMD_I == EVT) clr = old[EVT[3:0]];
    if (m_ack) begin
      m_ack = 0;
    end else begin
      if (!m_pend && LCL_REQ) begin
        m_pend = 1; m_pwe = LCL_WE; m_padr = LCL_ADR; m_pwdat = LCL_WDAT;
      end
      if (m_pend && !SMB_WREN) begin
        m_pend = 0; m_ack = 1; m_rd = !m_pwe;
        m_rdat = (m_padr < 8'(NR)) ? old[m_padr[3:0]] : 8'hFF;
        if (m_pwe && m_padr < 8'(NR)) begin
          if (m_padr == EVT) clr = clr | m_pwdat;
          else m_bank[m_padr[3:0]] = m_pwdat;
          chg = 1; cadr = m_padr;
        end
      end
    end
    m_bank[EVT[3:0]] = (old[EVT[3:0]] & ~clr) | EVT_I;
    m_chg = chg;
    if (chg) m_chg_adr = cadr;
  endtask

  initial begin
    vec_t v;
    logic [NR*8-1:0] img;
    logic rq_on;
    int   rq_gap;
    logic rq_we;
    logic [7:0] rq_adr, rq_wdat;

    // wren cmd dat rden evt | lreq lwe ladr lwdat | dato | chg adr | ack rdchk rdat | bidx bank
    vecs.push_back(mk(1, 8'h05, 8'h3C, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h05, 0, 0, 8'h00, 5, 8'h3C));
    vecs.push_back(mk(0, 8'h05, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h3C, 0, 8'h05, 0, 0, 8'h00, 5, 8'h3C));
    vecs.push_back(mk(1, 8'h05, 8'h11, 0, 8'h00, 1, 1, 8'h05, 8'h77, 8'h3C, 1, 8'h05, 0, 0, 8'h00, 5, 8'h11));
    vecs.push_back(mk(0, 8'h05, 8'h00, 0, 8'h00, 1, 1, 8'h05, 8'h77, 8'h11, 1, 8'h05, 1, 0, 8'h00, 5, 8'h77));
    vecs.push_back(mk(0, 8'h05, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h77, 0, 8'h05, 0, 0, 8'h00, 5, 8'h77));
    vecs.push_back(mk(0, 8'h05, 8'h00, 0, 8'h00, 1, 0, 8'h05, 8'h00, 8'h77, 0, 8'h05, 1, 1, 8'h77, 5, 8'h77));
    vecs.push_back(mk(0, 8'h05, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h77, 0, 8'h05, 0, 1, 8'h77, 5, 8'h77));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h04, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h05, 0, 0, 8'h00, 0, 8'h04));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h04, 0, 8'h05, 0, 0, 8'h00, 0, 8'h04));
    vecs.push_back(mk(0, 8'h00, 8'h00, 1, 8'h01, 0, 0, 8'h00, 8'h00, 8'h04, 0, 8'h05, 0, 0, 8'h00, 0, 8'h01));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h01, 0, 8'h05, 0, 0, 8'h00, 0, 8'h01));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 1, 1, 8'h00, 8'h01, 8'h01, 1, 8'h00, 1, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 8'h00, 8'hFF, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00));
    vecs.push_back(mk(1, 8'h14, 8'h55, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'hFF, 0, 8'h00, 0, 0, 8'h00, 5, 8'h77));
    vecs.push_back(mk(0, 8'h05, 8'h00, 0, 8'h00, 1, 1, 8'h14, 8'h66, 8'h77, 0, 8'h00, 1, 0, 8'h00, 5, 8'h77));
    vecs.push_back(mk(0, 8'h05, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h77, 0, 8'h00, 0, 0, 8'h00, 5, 8'h77));
`ifdef SMBREG_WRLOCK_EN
    vecs.push_back(mk(1, 8'h0F, 8'h01, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h0F, 0, 0, 8'h00, 15, 8'h01));
    vecs.push_back(mk(1, 8'h02, 8'hAA, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h0F, 0, 0, 8'h00, 2, 8'h00));
    vecs.push_back(mk(0, 8'h02, 8'h00, 0, 8'h00, 1, 1, 8'h02, 8'hBB, 8'h00, 1, 8'h02, 1, 0, 8'h00, 2, 8'hBB));
    vecs.push_back(mk(1, 8'h0F, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'h01, 1, 8'h0F, 0, 0, 8'h00, 15, 8'h00));
    vecs.push_back(mk(0, 8'h02, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 8'hBB, 0, 8'h0F, 0, 0, 8'h00, 2, 8'hBB));
`endif

    do_reset();

    // reset state
    SMB_CMD_I = 8'h03; #1;
    chk("rst_dato_3", SMB_DAT_O, 8'h00);
    SMB_CMD_I = 8'hF0; #1;
    chk("rst_dato_f0", SMB_DAT_O, 8'hFF);
    chk("rst_ack", LCL_ACK, 0);
    chk("rst_rdat", LCL_RDAT, 0);
    chk("rst_chg", REG_CHG, 0);
    chk("rst_chg_adr", REG_CHG_ADR, 0);
    chk("rst_regs", REGS_O, 0);
    @(negedge CLK_IN);

    // directed table
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.wren, v.cmd, v.dat, v.rden, v.evt, v.lreq, v.lwe, v.ladr, v.lwdat);
      #1;
      chk($sformatf("v%0d_dato", i), SMB_DAT_O, v.e_dato);
      tick();
      chk($sformatf("v%0d_chg", i), REG_CHG, v.e_chg);
      chk($sformatf("v%0d_chg_adr", i), REG_CHG_ADR, v.e_chg_adr);
      chk($sformatf("v%0d_ack", i), LCL_ACK, v.e_ack);
      if (v.rd_chk) chk($sformatf("v%0d_rdat", i), LCL_RDAT, v.e_rdat);
      chk($sformatf("v%0d_bank", i), REGS_O[v.bidx*8 +: 8], v.e_bank);
    end

    // deferred read across two SMBus writes, REQ dropped while waiting
    drive(1, 8'h06, 8'hA1, 0, 0, 1, 0, 8'h05, 8'h00); tick();
    chk("w2_ack0", LCL_ACK, 0);
    chk("w2_chg0", REG_CHG_ADR, 8'h06);
    drive(1, 8'h06, 8'hA2, 0, 0, 0, 0, 8'h00, 8'h00); tick();
    chk("w2_ack1", LCL_ACK, 0);
    chk("w2_chg1", REG_CHG, 1);
    drive(0, 8'h06, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00); tick();
    chk("w2_ack2", LCL_ACK, 1);
    chk("w2_rdat", LCL_RDAT, 8'h77);
    chk("w2_nochg", REG_CHG, 0);
    drive(0, 8'h06, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00); tick();
    chk("w2_ack3", LCL_ACK, 0);
    chk("w2_bank6", REGS_O[6*8 +: 8], 8'hA2);

    // REQ still high through the ACK cycle counts as a new request
    drive(0, 8'h06, 8'h00, 0, 0, 1, 0, 8'h06, 8'h00); tick();
    chk("bb_ack0", LCL_ACK, 1);
    chk("bb_rdat0", LCL_RDAT, 8'hA2);
    drive(0, 8'h06, 8'h00, 0, 0, 1, 0, 8'h05, 8'h00); tick();
    chk("bb_ack1", LCL_ACK, 0);
    drive(0, 8'h06, 8'h00, 0, 0, 1, 0, 8'h05, 8'h00); tick();
    chk("bb_ack2", LCL_ACK, 1);
    chk("bb_rdat2", LCL_RDAT, 8'h77);
    drive(0, 8'h06, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00); tick();
    chk("bb_ack3", LCL_ACK, 0);

    // randomized traffic against the reference model
    do_reset();
    rq_on = 0; rq_gap = 0; rq_we = 0; rq_adr = 0; rq_wdat = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rq_on && m_ack) begin
        rq_on = 0;
        rq_gap = $urandom_range(0, 3);
      end else if (!rq_on) begin
        if (rq_gap > 0) rq_gap--;
        else if ($urandom_range(0, 1) == 1) begin
          rq_on = 1;
          rq_we = 1'($urandom_range(0, 1));
          rq_adr = 8'($urandom_range(0, 19));
          rq_wdat = 8'($urandom);
        end
      end
      drive(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 19)), 8'($urandom),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 5) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00,
            rq_on, rq_we, rq_adr, rq_wdat);
      #1;
      chk("rnd_dato", SMB_DAT_O, m_read(SMB_CMD_I));
      model_edge();
      tick();
      chk("rnd_chg", REG_CHG, m_chg);
      chk("rnd_chg_adr", REG_CHG_ADR, m_chg_adr);
      chk("rnd_ack", LCL_ACK, m_ack);
      if (m_ack && m_rd) chk("rnd_rdat", LCL_RDAT, m_rdat);
      for (int k = 0; k < NR; k++) img[k*8 +: 8] = m_bank[k];
      chk("rnd_regs", REGS_O, img);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
